// File: rtl/serial_adder_if.sv
// Start/busy/done handshake plus operand and result bus for serial_adder.
// The master drives a request; the slave (the adder) answers with busy/done and the result.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             co;
   logic             ovf;

   modport master (
      output start, a, b, ci, sub,
      input  busy, done, s, co, ovf
   );

   modport slave (
      input  start, a, b, ci, sub,
      output busy, done, s, co, ovf
   );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a ripple slice and a
// registered carry, WIDTH/DIGIT RUN cycles per operation, result held until the next completion.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             co_q, co_d;
   logic             ovf_q, ovf_d;

   logic [DIGIT-1:0] dig_sum;
   logic             dig_cin_msb;
   logic             dig_cout;
   logic [WIDTH-1:0] acc_next;

   // Ripple through the low DIGIT operand bits; the carry into the slice MSB is
   // kept because on the final step that bit is the word MSB and feeds ovf.
   always_comb begin : digit_slice
      logic c;
      c           = carry_q;
      dig_sum     = '0;
      dig_cin_msb = 1'b0;
      for (int i = 0; i < DIGIT; i++) begin
         dig_sum[i] = a_sh_q[i] ^ b_sh_q[i] ^ c;
         if (i == DIGIT - 1) begin
            dig_cin_msb = c;
         end
         c = (a_sh_q[i] & b_sh_q[i]) | (c & (a_sh_q[i] ^ b_sh_q[i]));
      end
      dig_cout = c;
   end

   // New digits enter at the top and shift down, so after STEPS shifts the first digit sits at bit 0.
   assign acc_next = WIDTH'({dig_sum, acc_q} >> DIGIT);

   always_comb begin : next_state
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      acc_d   = acc_q;
      s_d     = s_q;
      co_d    = co_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = RUN;
               a_sh_d  = bus.a;
               b_sh_d  = bus.b ^ {WIDTH{bus.sub}};
               carry_d = bus.sub | bus.ci;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_sh_d  = a_sh_q >> DIGIT;
            b_sh_d  = b_sh_q >> DIGIT;
            carry_d = dig_cout;
            acc_d   = acc_next;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
               state_d = DONE;
               s_d     = acc_next;
               co_d    = dig_cout;
               ovf_d   = dig_cin_msb ^ dig_cout;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: the datapath registers are reset along with the FSM so an aborted operation leaves no residue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         acc_q   <= '0;
         s_q     <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         acc_q   <= acc_d;
         s_q     <= s_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.s    = s_q;
   assign bus.co   = co_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench: five adder configurations share one stimulus stream; an arithmetic
// reference model predicts acceptance, completion edge and result for each configuration.
module tb_serial_adder;

   localparam int N = 5;

   typedef struct {
      logic [7:0] s;
      logic       co;
      logic       ovf;
      int         done_edge;
   } exp_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      logic       sub;
   } op_t;

   localparam op_t DIR_OPS [10] = '{
      '{8'h5A, 8'h3C, 1'b0, 1'b0},
      '{8'hFF, 8'h01, 1'b0, 1'b0},
      '{8'h01, 8'h01, 1'b1, 1'b0},
      '{8'h05, 8'h07, 1'b0, 1'b1},
      '{8'h80, 8'h01, 1'b0, 1'b1},
      '{8'h80, 8'h01, 1'b1, 1'b1},
      '{8'hF0, 8'h10, 1'b0, 1'b0},
      '{8'h7F, 8'h01, 1'b0, 1'b0},
      '{8'h00, 8'h00, 1'b0, 1'b1},
      '{8'h80, 8'h80, 1'b0, 1'b0}
   };

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_r = 1'b0;
   logic [7:0] a_r = '0;
   logic [7:0] b_r = '0;
   logic       ci_r = 1'b0;
   logic       sub_r = 1'b0;

   int cycle = 0;
   int n_checks = 0;
   int n_errors = 0;
   int next_free [N] = '{default: 0};
   int accepted  [N] = '{default: 0};
   int base      [N] = '{default: 0};
   exp_t exp_q [N][$];

   always #5 clk = ~clk;

   function automatic int width_of(int k);
      return (k == 4) ? 1 : 8;
   endfunction

   function automatic int steps_of(int k);
      return (k == 4) ? 1 : (8 >> k);
   endfunction

   // Reference: plain integer arithmetic, unsigned for s/co, signed range test for ovf.
   function automatic exp_t ref_add(int w, logic [7:0] a, logic [7:0] b, logic ci, logic sub,
                                    int done_edge);
      exp_t   e;
      longint m, ua, ub, sa, sb, us, ss;
      m  = longint'(1) << w;
      ua = longint'(a) & (m - 1);
      ub = longint'(b) & (m - 1);
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      if (sub) begin
         us   = ua - ub;
         ss   = sa - sb;
         e.co = (ua >= ub);
      end else begin
         us   = ua + ub + (ci ? 1 : 0);
         ss   = sa + sb + (ci ? 1 : 0);
         e.co = (us >= m);
      end
      e.s         = 8'(us & (m - 1));
      e.ovf       = (ss < -(m / 2)) || (ss >= m / 2);
      e.done_edge = done_edge;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic fail(input string name, input int act, input int exp);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
   endtask

   // Acceptance model: a start sampled on edge E is taken when the unit is free,
   // completes on edge E+STEPS, and the unit is free again from edge E+STEPS+1.
   always @(posedge clk) begin
      cycle <= cycle + 1;
      for (int k = 0; k < N; k++) begin
         if (!rst_n) begin
            next_free[k] <= 0;
            exp_q[k].delete();
         end else if (start_r && (cycle + 1 >= next_free[k])) begin
            exp_q[k].push_back(ref_add(width_of(k), a_r, b_r, ci_r, sub_r,
                                       cycle + 1 + steps_of(k)));
            next_free[k] <= cycle + 2 + steps_of(k);
            accepted[k]  <= accepted[k] + 1;
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      localparam int W = (gi == 4) ? 1 : 8;
      localparam int D = (gi == 4) ? 1 : (1 << gi);

      serial_adder_if #(.WIDTH(W)) bus ();

      assign bus.start = start_r;
      assign bus.a     = a_r[W-1:0];
      assign bus.b     = b_r[W-1:0];
      assign bus.ci    = ci_r;
      assign bus.sub   = sub_r;

      serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );

      logic [7:0] last_s   = '0;
      logic       last_co  = 1'b0;
      logic       last_ovf = 1'b0;

      always @(negedge clk) begin
         if (!rst_n) begin
            check($sformatf("inst%0d.reset_outputs", gi),
                  {bus.busy, bus.done, bus.co, bus.ovf, 8'(bus.s)}, 32'd0);
            last_s   <= '0;
            last_co  <= 1'b0;
            last_ovf <= 1'b0;
         end else begin
            check($sformatf("inst%0d.busy", gi), bus.busy, (cycle < next_free[gi] - 1));
            if (exp_q[gi].size() != 0 && exp_q[gi][0].done_edge < cycle) begin
               fail($sformatf("inst%0d.done_missing_edge", gi), cycle, exp_q[gi][0].done_edge);
               void'(exp_q[gi].pop_front());
            end
            if (bus.done) begin
               if (exp_q[gi].size() == 0) begin
                  fail($sformatf("inst%0d.spurious_done_queue", gi), 1, 0);
               end else begin
                  check($sformatf("inst%0d.done_edge", gi), cycle, exp_q[gi][0].done_edge);
                  check($sformatf("inst%0d.s", gi), 8'(bus.s), exp_q[gi][0].s);
                  check($sformatf("inst%0d.co", gi), bus.co, exp_q[gi][0].co);
                  check($sformatf("inst%0d.ovf", gi), bus.ovf, exp_q[gi][0].ovf);
                  void'(exp_q[gi].pop_front());
               end
               last_s   <= 8'(bus.s);
               last_co  <= bus.co;
               last_ovf <= bus.ovf;
            end else begin
               check($sformatf("inst%0d.result_hold", gi),
                     {bus.co, bus.ovf, 8'(bus.s)}, {last_co, last_ovf, last_s});
            end
         end
      end
   end

   function automatic bit all_free();
      for (int k = 0; k < N; k++) begin
         if (cycle + 1 < next_free[k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic bit enough();
      for (int k = 0; k < N; k++) begin
         if (accepted[k] - base[k] < 1000) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic wait_free();
      int waited = 0;
      while (!all_free() && waited < 50) begin
         @(negedge clk); #1;
         waited++;
      end
      if (!all_free()) fail("wait_free_timeout", waited, 50);
   endtask

   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub);
      wait_free();
      a_r     = a;
      b_r     = b;
      ci_r    = ci;
      sub_r   = sub;
      start_r = 1'b1;
      @(negedge clk); #1;
      start_r = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;

      // Full-adder truth table (meaningful for the 1-bit instance, small sums elsewhere).
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         issue({7'd0, v[2]}, {7'd0, v[1]}, v[0], 1'b0);
      end

      for (int i = 0; i < 10; i++) begin
         issue(DIR_OPS[i].a, DIR_OPS[i].b, DIR_OPS[i].ci, DIR_OPS[i].sub);
      end

      // A start arriving on the third RUN edge of the DIGIT=1 unit must be ignored there.
      issue(8'h12, 8'h34, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      a_r     = 8'hAA;
      b_r     = 8'h55;
      start_r = 1'b1;
      @(negedge clk); #1;
      start_r = 1'b0;

      // Start held high: each unit restarts on every DONE cycle with whatever a/b are present.
      wait_free();
      start_r = 1'b1;
      for (int i = 0; i < 20; i++) begin
         a_r   = 8'($urandom);
         b_r   = 8'($urandom);
         ci_r  = 1'($urandom);
         sub_r = 1'($urandom);
         @(negedge clk); #1;
      end
      start_r = 1'b0;

      // Reset after the fourth RUN edge, then a start on the first edge after release.
      issue(8'h33, 8'h44, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk); #1;
      rst_n   = 1'b1;
      a_r     = 8'h21;
      b_r     = 8'h0F;
      ci_r    = 1'b0;
      sub_r   = 1'b0;
      start_r = 1'b1;
      @(negedge clk); #1;
      start_r = 1'b0;
      wait_free();

      for (int k = 0; k < N; k++) base[k] = accepted[k];
      for (int c = 0; c < 40000 && !enough(); c++) begin
         start_r = ($urandom_range(3) != 0);
         a_r     = 8'($urandom);
         b_r     = 8'($urandom);
         ci_r    = 1'($urandom);
         sub_r   = 1'($urandom);
         @(negedge clk); #1;
      end
      start_r = 1'b0;
      if (!enough()) fail("random_op_budget", accepted[0] - base[0], 1000);

      repeat (20) @(negedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         check($sformatf("inst%0d.queue_drained", k), exp_q[k].size(), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
